vote_result_display: RTL and testbench



---
 rtl/vote_display_pkg.sv | 33 +++
 rtl/vote_result_display_bin2bcd_seq.sv | 95 +++++++++
 rtl/vote_result_display.sv | 231 +++++++++++++++++++++++
 tb/tb_vote_result_display.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_display_pkg.sv
// vote_display_pkg
//   Shared definitions for the vote result display block:
//     NUM_CAND       number of candidates shown
//     SEG_BLANK      all segments off (active-low)
//     SEG_DIGIT      active-low {g,f,e,d,c,b,a} patterns for 0..9
//     conv_state_t   binary-to-BCD conversion FSM states
//     seg_of()       digit -> segment pattern, blank for values above 9
package vote_display_pkg;

    localparam int NUM_CAND = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_DIGIT[digit];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/vote_result_display_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential 8-bit binary to 3-digit BCD converter (double dabble).
//   One conversion takes LOAD (1 cycle) + SHIFT (8 cycles) + DONE (1 cycle);
//   the BCD outputs change only in DONE, so a half-converted value is never
//   visible downstream.
//   Ports:
//     clock, reset       system clock, synchronous active-high reset
//     start              request a conversion; accepted in IDLE or DONE
//     bin[7:0]           value to convert, sampled during LOAD
//     busy               FSM is not in IDLE
//     done               FSM is in DONE (final cycle of a conversion)
//     hund/tens/units    converted BCD digits
module bin2bcd_seq
    import vote_display_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_t state;
    conv_state_t state_nxt;
    logic [2:0]  shift_cnt;
    // {hundreds, tens, units, binary} working register
    logic [19:0] work;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] w);
        logic [19:0] t;
        t = w;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_cnt <= '0;
        end else if (state == LOAD) begin
            shift_cnt <= '0;
        end else if (state == SHIFT) begin
            shift_cnt <= shift_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (state == LOAD) begin
            work <= {12'd0, bin};
        end else if (state == SHIFT) begin
            work <= dabble_step(work);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hund  <= '0;
            tens  <= '0;
            units <= '0;
        end else if (state == DONE) begin
            hund  <= work[19:16];
            tens  <= work[15:12];
            units <= work[11:8];
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/vote_result_display.sv
// vote_result_display
//   Result stage of the voting machine. Shows one candidate at a time on a
//   4-digit multiplexed active-low seven-segment display: digit 3 is the
//   candidate number (with dp), digits 2..0 the tally with leading-zero
//   blanking. The candidate advances on next_pulse or every ROTATE_CYCLES.
//   Optional leader detector enabled by defining WINNER_DETECT_EN.
//   Parameters: CLK_HZ (informational), SCAN_DIV (cycles per digit slot),
//               ROTATE_CYCLES (cycles between automatic advances).
//   Ports:
//     clock, reset                 system clock, synchronous active-high reset
//     mode                         0 = voting (display blank), 1 = results
//     cand1_votes..cand4_votes     per-candidate tallies
//     next_pulse                   one-cycle request to show the next candidate
//     seg[6:0], an[3:0], dp        display drive, all active-low, registered
//     winner_valid, winner_idx, tie  leader outputs (0 unless WINNER_DETECT_EN)
module vote_result_display
    import vote_display_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int SCAN_DIV      = 100_000,
    parameter int ROTATE_CYCLES = 200_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] cand1_votes,
    input  logic [7:0] cand2_votes,
    input  logic [7:0] cand3_votes,
    input  logic [7:0] cand4_votes,
    input  logic       next_pulse,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       winner_valid,
    output logic [1:0] winner_idx,
    output logic       tie
);

    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int ROT_W  = $clog2(ROTATE_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROTATE_CYCLES - 1);

    // CLK_HZ does not drive logic; it only takes part in this sanity check.
    if (CLK_HZ <= 0 || SCAN_DIV < 1 || ROTATE_CYCLES < 2) begin : g_bad_params
        $error("vote_result_display: invalid timing parameters");
    end

    logic [7:0] tally [NUM_CAND];
    assign tally[0] = cand1_votes;
    assign tally[1] = cand2_votes;
    assign tally[2] = cand3_votes;
    assign tally[3] = cand4_votes;

    // ---- candidate selection and auto-rotate ----
    logic [1:0]       sel;
    logic [ROT_W-1:0] rot_cnt;
    logic             advance;

    // A pulse and the terminal count in the same cycle collapse to one advance.
    assign advance = mode && (next_pulse || rot_cnt == ROT_LAST);

    always_ff @(posedge clock) begin
        if (reset || !mode) begin
            sel     <= '0;
            rot_cnt <= '0;
        end else if (advance) begin
            sel     <= sel + 2'd1;
            rot_cnt <= '0;
        end else begin
            rot_cnt <= rot_cnt + ROT_W'(1);
        end
    end

    // ---- conversion control ----
    logic       mode_p1;
    logic       load_p1;
    logic       pending;
    logic       trig;
    logic       start;
    logic       conv_busy;
    logic       conv_done;
    logic [1:0] snap_sel;
    logic [7:0] snap_val;
    logic [7:0] sel_tally;
    logic [1:0] disp_sel;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;

    assign sel_tally = tally[sel];

    // The snapshot is being written during LOAD, so the difference test is
    // masked then; otherwise every conversion would re-trigger itself.
    assign trig  = mode && (!mode_p1 ||
                   (!load_p1 && (sel != snap_sel || sel_tally != snap_val)));
    assign start = mode && ((!conv_busy && (trig || pending)) ||
                            (conv_done && pending));

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_p1 <= 1'b0;
            load_p1 <= 1'b0;
            pending <= 1'b0;
        end else begin
            mode_p1 <= mode;
            load_p1 <= start;
            if (start) begin
                pending <= 1'b0;
            end else if (trig) begin
                pending <= 1'b1;
            end
        end
    end

    // ---- stage p1: snapshot taken in the LOAD cycle ----
    always_ff @(posedge clock) begin
        if (load_p1) begin
            snap_sel <= sel;
            snap_val <= sel_tally;
        end
    end

    // Candidate number is committed together with its BCD value.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_sel <= '0;
        end else if (conv_done) begin
            disp_sel <= snap_sel;
        end
    end

    bin2bcd_seq u_bcd (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (sel_tally),
        .busy  (conv_busy),
        .done  (conv_done),
        .hund  (bcd_hund),
        .tens  (bcd_tens),
        .units (bcd_units)
    );

    // ---- digit scan ----
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        slot;
    logic [6:0]        digit_seg;
    logic              digit_dp;

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            slot     <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            slot     <= slot + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        digit_dp  = 1'b1;
        case (slot)
            2'd3: begin
                digit_seg = seg_of({2'b00, disp_sel} + 4'd1);
                digit_dp  = 1'b0;
            end
            2'd2: digit_seg = (bcd_hund == 4'd0) ? SEG_BLANK : seg_of(bcd_hund);
            2'd1: digit_seg = (bcd_hund == 4'd0 && bcd_tens == 4'd0) ?
                              SEG_BLANK : seg_of(bcd_tens);
            default: digit_seg = seg_of(bcd_units);
        endcase
    end

    // ---- stage p1: registered display drive ----
    always_ff @(posedge clock) begin
        if (reset || !mode) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= digit_seg;
            an  <= ~(4'b0001 << slot);
            dp  <= digit_dp;
        end
    end

    // ---- leader detector ----
`ifdef WINNER_DETECT_EN
    logic [7:0] lead_val;
    logic [1:0] lead_idx;
    logic [2:0] lead_cnt;

    // Strict '>' keeps the lowest index when several share the maximum.
    always_comb begin
        lead_val = tally[0];
        lead_idx = 2'd0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > lead_val) begin
                lead_val = tally[i];
                lead_idx = 2'(i);
            end
        end
        lead_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (tally[i] == lead_val) lead_cnt = lead_cnt + 3'd1;
        end
    end

    // ---- stage p1: registered leader outputs ----
    always_ff @(posedge clock) begin
        if (reset) begin
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            tie          <= 1'b0;
        end else begin
            winner_valid <= mode && (lead_val != 8'd0);
            winner_idx   <= lead_idx;
            tie          <= (lead_cnt >= 3'd2);
        end
    end
`else
    assign winner_valid = 1'b0;
    assign winner_idx   = 2'd0;
    assign tie          = 1'b0;
`endif

endmodule

// File: tb/tb_vote_result_display.sv
module tb_vote_result_display;

    localparam int SCAN_DIV = 4;
    localparam int ROT      = 64;
`ifdef WINNER_DETECT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [7:0] c1, c2, c3, c4;
    logic       next_pulse;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       winner_valid;
    logic [1:0] winner_idx;
    logic       tie;

    always #5 clock = ~clock;

    vote_result_display #(
        .CLK_HZ        (100_000_000),
        .SCAN_DIV      (SCAN_DIV),
        .ROTATE_CYCLES (ROT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .cand1_votes  (c1),
        .cand2_votes  (c2),
        .cand3_votes  (c3),
        .cand4_votes  (c4),
        .next_pulse   (next_pulse),
        .seg          (seg),
        .an           (an),
        .dp           (dp),
        .winner_valid (winner_valid),
        .winner_idx   (winner_idx),
        .tie          (tie)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference segment encoding, written as the inverse of the common
    // active-high 7-segment patterns. Anything outside 0..9 is blank.
    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return ~7'h3F;
            1: return ~7'h06;
            2: return ~7'h5B;
            3: return ~7'h4F;
            4: return ~7'h66;
            5: return ~7'h6D;
            6: return ~7'h7D;
            7: return ~7'h07;
            8: return ~7'h7F;
            9: return ~7'h6F;
            default: return 7'h7F;
        endcase
    endfunction

    // Behavioural model of what each digit position should show.
    function automatic logic [6:0] exp_digit(input int pos, input int s, input int v);
        case (pos)
            3: return ref_seg(s + 1);
            2: return (v >= 100) ? ref_seg(v / 100) : 7'h7F;
            1: return (v >= 10) ? ref_seg((v / 10) % 10) : 7'h7F;
            default: return ref_seg(v % 10);
        endcase
    endfunction

    logic [6:0] cap_seg [4];
    logic [3:0] cap_dp;
    logic [3:0] cap_seen;
    int         cap_bad_an;

    task automatic capture();
        cap_seen   = 4'h0;
        cap_bad_an = 0;
        cap_dp     = 4'hF;
        for (int k = 0; k < 4; k++) cap_seg[k] = 7'h7F;
        repeat (20) begin
            @(negedge clock);
            case (an)
                4'b1110: begin cap_seg[0] = seg; cap_dp[0] = dp; cap_seen[0] = 1'b1; end
                4'b1101: begin cap_seg[1] = seg; cap_dp[1] = dp; cap_seen[1] = 1'b1; end
                4'b1011: begin cap_seg[2] = seg; cap_dp[2] = dp; cap_seen[2] = 1'b1; end
                4'b0111: begin cap_seg[3] = seg; cap_dp[3] = dp; cap_seen[3] = 1'b1; end
                default: cap_bad_an++;
            endcase
        end
    endtask

    task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        capture();
        chk({tag, "_scan"}, int'(cap_seen), 15);
        chk({tag, "_an_onehot"}, cap_bad_an, 0);
        chk({tag, "_d3"}, int'(cap_seg[3]), int'(e3));
        chk({tag, "_d2"}, int'(cap_seg[2]), int'(e2));
        chk({tag, "_d1"}, int'(cap_seg[1]), int'(e1));
        chk({tag, "_d0"}, int'(cap_seg[0]), int'(e0));
        chk({tag, "_dp"}, int'(cap_dp), 4'b0111);
    endtask

    // Blank, load tallies, enter result mode, step np times, let it settle.
    task automatic run_entry(input int a, input int b, input int c, input int d, input int np);
        @(negedge clock);
        mode = 1'b0;
        c1 = 8'(a); c2 = 8'(b); c3 = 8'(c); c4 = 8'(d);
        repeat (2) @(negedge clock);
        mode = 1'b1;
        for (int p = 0; p < np; p++) begin
            @(negedge clock); next_pulse = 1'b1;
            @(negedge clock); next_pulse = 1'b0;
        end
        repeat (24) @(negedge clock);
    endtask

    typedef struct {
        int a, b, c, d, np;
        int d3, d2, d1, d0;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int tv [4];
        int s, v, np, mx, mi, cnt;
        bit m;

        tbl[0] = '{5,   0,   0, 0,   0, 1, -1, -1, 5};
        tbl[1] = '{5,   255, 0, 0,   1, 2,  2,  5, 5};
        tbl[2] = '{0,   0,   0, 0,   2, 3, -1, -1, 0};
        tbl[3] = '{1,   2,   3, 100, 3, 4,  1,  0, 0};
        tbl[4] = '{10,  0,   0, 0,   0, 1, -1,  1, 0};
        tbl[5] = '{99,  1,   1, 1,   0, 1, -1,  9, 9};
        tbl[6] = '{0,   205, 7, 0,   1, 2,  2,  0, 5};
        tbl[7] = '{42,  1,   1, 1,   4, 1, -1,  4, 2};

        reset = 1'b1; mode = 1'b0; next_pulse = 1'b0;
        c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
        repeat (3) @(negedge clock);
        chk("rst_seg", int'(seg), 7'h7F);
        chk("rst_an", int'(an), 4'hF);
        chk("rst_dp", int'(dp), 1);
        chk("rst_wvalid", int'(winner_valid), 0);
        chk("rst_widx", int'(winner_idx), 0);
        chk("rst_tie", int'(tie), 0);
        chk("rst_pending", int'(dut.pending), 0);
        chk("rst_busy", int'(dut.conv_busy), 0);
        reset = 1'b0;

        // Table-driven display vectors
        for (int i = 0; i < 8; i++) begin
            run_entry(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].np);
            check_disp($sformatf("vec%0d", i), ref_seg(tbl[i].d3), ref_seg(tbl[i].d2),
                       ref_seg(tbl[i].d1), ref_seg(tbl[i].d0));
        end

        // Randomized display checks against the behavioural model
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) tv[k] = int'($urandom_range(0, 255));
            np = int'($urandom_range(0, 4));
            run_entry(tv[0], tv[1], tv[2], tv[3], np);
            s = np % 4;
            v = tv[s];
            check_disp($sformatf("rnd%0d", i), exp_digit(3, s, v), exp_digit(2, s, v),
                       exp_digit(1, s, v), exp_digit(0, s, v));
        end

        // next_pulse coinciding with the rotate terminal count: one advance
        @(negedge clock);
        mode = 1'b0; c1 = 8'd11; c2 = 8'd22; c3 = 8'd33; c4 = 8'd44;
        repeat (2) @(negedge clock);
        mode = 1'b1;
        repeat (ROT - 1) @(negedge clock);
        next_pulse = 1'b1;
        @(negedge clock);
        next_pulse = 1'b0;
        repeat (22) @(negedge clock);
        check_disp("coincide", ref_seg(2), 7'h7F, ref_seg(2), ref_seg(2));

        // Automatic rotation 0->1->2->3->0, one step every ROT cycles
        @(negedge clock);
        mode = 1'b0;
        repeat (2) @(negedge clock);
        mode = 1'b1;
        repeat (ROT - 1 + 25) @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            s = k % 4;
            v = 11 * (s + 1);
            check_disp($sformatf("rot%0d", k), exp_digit(3, s, v), exp_digit(2, s, v),
                       exp_digit(1, s, v), exp_digit(0, s, v));
            repeat (ROT - 20) @(negedge clock);
        end

        // Voting mode blanks the display and forces candidate 1
        mode = 1'b0;
        @(negedge clock);
        chk("mode0_an", int'(an), 4'hF);
        chk("mode0_seg", int'(seg), 7'h7F);
        chk("mode0_dp", int'(dp), 1);
        repeat (5) @(negedge clock);
        chk("mode0_an_hold", int'(an), 4'hF);
        run_entry(11, 22, 33, 44, 0);
        check_disp("mode0_sel0", ref_seg(1), 7'h7F, ref_seg(1), ref_seg(1));

        // Tally changes 10 -> 99 while a conversion is shifting
        @(negedge clock);
        mode = 1'b0; c1 = 8'd10;
        repeat (2) @(negedge clock);
        mode = 1'b1;
        repeat (4) @(negedge clock);
        c1 = 8'd99;
        @(negedge clock);
        chk("pend_set", int'(dut.pending), 1);
        repeat (6) @(negedge clock);
        chk("pend_first_h", int'(dut.bcd_hund), 0);
        chk("pend_first_t", int'(dut.bcd_tens), 1);
        chk("pend_first_u", int'(dut.bcd_units), 0);
        repeat (10) @(negedge clock);
        chk("pend_second_t", int'(dut.bcd_tens), 9);
        chk("pend_second_u", int'(dut.bcd_units), 9);
        chk("pend_clear", int'(dut.pending), 0);
        check_disp("pend_disp", ref_seg(1), 7'h7F, ref_seg(9), ref_seg(9));

        // Reset in the middle of a conversion
        @(negedge clock);
        mode = 1'b0; c1 = 8'd200;
        repeat (2) @(negedge clock);
        mode = 1'b1;
        repeat (4) @(negedge clock);
        c1 = 8'd201;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_seg", int'(seg), 7'h7F);
        chk("midrst_an", int'(an), 4'hF);
        chk("midrst_dp", int'(dp), 1);
        chk("midrst_busy", int'(dut.conv_busy), 0);
        chk("midrst_pending", int'(dut.pending), 0);
        reset = 1'b0;
        repeat (24) @(negedge clock);
        check_disp("after_rst", ref_seg(1), ref_seg(2), ref_seg(0), ref_seg(1));

        // Leader detector, fixed cases
        mode = 1'b1; c1 = 8'd7; c2 = 8'd9; c3 = 8'd9; c4 = 8'd3;
        @(negedge clock);
        chk("win_7993_valid", int'(winner_valid), WD ? 1 : 0);
        chk("win_7993_idx", int'(winner_idx), WD ? 1 : 0);
        chk("win_7993_tie", int'(tie), WD ? 1 : 0);
        c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
        @(negedge clock);
        chk("win_zero_valid", int'(winner_valid), 0);
        chk("win_zero_idx", int'(winner_idx), 0);

        // Leader detector, randomized against the model
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 4; k++) begin
                tv[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                                    : int'($urandom_range(0, 255));
            end
            m = ($urandom_range(0, 3) != 0);
            mode = m;
            c1 = 8'(tv[0]); c2 = 8'(tv[1]); c3 = 8'(tv[2]); c4 = 8'(tv[3]);
            @(negedge clock);
            mx = tv[0]; mi = 0;
            for (int k = 1; k < 4; k++) if (tv[k] > mx) begin mx = tv[k]; mi = k; end
            cnt = 0;
            for (int k = 0; k < 4; k++) if (tv[k] == mx) cnt++;
            chk($sformatf("rwin%0d_valid", n), int'(winner_valid), (WD && m && mx != 0) ? 1 : 0);
            chk($sformatf("rwin%0d_idx", n), int'(winner_idx), WD ? mi : 0);
            chk($sformatf("rwin%0d_tie", n), int'(tie), (WD && cnt >= 2) ? 1 : 0);
        end

        mode = 1'b0;
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
